lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter BIG_ENDIAN, default 1, byte offset 0 maps to lane bits [31:24]; 0 = offset 0 maps to bits [7:0].
REQ-002 Parameter ALIGN_ADDR, default 1, data_addr low 2 bits forced to 0; 0 = raw address driven.
REQ-003 clk  in  1  the block's single clock.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 valid_i  in  1  M-stage holds a memory op.
REQ-006 op_i  in  6  opcode; OP_LB/LBU/LH/LHU/LW/SB/SH/SW from defines.vh; other codes are no-ops.
REQ-007 addr_i  in  32  effective address.
REQ-008 wdata_i  in  32  store source register.
REQ-009 flush_i  in  1  exception flush of M stage.
REQ-010 stall_o  out  1  hold pipeline.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 rdata_o  out  32  extended load result.
REQ-013 adel_o / ades_o  out  1 each  load / store address error.
REQ-014 badvaddr_o  out  32  faulting address.
REQ-015 data_req, data_wr  out  1 each; data_size  out  2; data_addr  out  32; data_wstrb  out  4; data_wdata  out  32  SRAM-like request channel.
REQ-016 data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32  SRAM-like response channel.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE, DRAIN.
REQ-018 Legal op = valid_i, memory opcode, aligned: halfword needs addr_i[0]=0; word needs addr_i[1:0]=0; byte is always aligned.
REQ-019 Combinational in IDLE: misaligned load -> adel_o=1; misaligned store -> ades_o=1; badvaddr_o=addr_i; no request; stall_o=0.
REQ-020 IDLE + legal op + !flush_i -> REQ; op, address and store data latched on that edge; stall_o=1 in IDLE for that cycle.
REQ-021 REQ: data_req=1, all request fields from latched values; on data_addr_ok -> WAIT.
REQ-022 Request fields:
- data_size: 0 = byte, 1 = half, 2 = word.
- data_wr=1 for stores.
- data_wdata: byte replicated x4, half replicated x2, word as is.
- data_wstrb: lane mask per BIG_ENDIAN; 0000 for loads.
REQ-023 WAIT: on data_data_ok -> DONE; for loads, data_rdata lane is selected by offset and BIG_ENDIAN, sign- or zero-extended to 32 bits, and registered into rdata_o.
REQ-024 DONE: done_o=1, stall_o=0, -> IDLE next cycle.
REQ-025 stall_o=1 in REQ, WAIT and DRAIN.
REQ-026 rdata_o holds its value until the next load completes; unchanged by stores, no-ops and errors.
REQ-027 Flush in IDLE or REQ -> IDLE; no request issued (or the request is withdrawn).
REQ-028 Flush in WAIT -> DRAIN; DRAIN waits for data_data_ok, then -> IDLE with no done_o and no rdata_o update.
REQ-029 data_data_ok is ignored in IDLE, REQ and DONE; data_addr_ok is ignored outside REQ.
REQ-030 Latency with addr_ok in the first REQ cycle and data_ok in the next cycle: valid_i to done_o = 4 cycles.

Reset
REQ-031 rst forces IDLE at any state, including mid-transaction.
REQ-032 Reset values: rdata_o=0, latched registers=0, data_req=0, done_o=0, stall_o=0.
REQ-033 A stale data_data_ok arriving after reset is ignored.

Verification
REQ-034 BIG_ENDIAN=1, LB addr 0x1001, data_rdata 0x8899AABB -> data_size 0, rdata_o 0xFFFFFF99, one done_o pulse.
REQ-035 BIG_ENDIAN=0, LHU addr 0x2002, data_rdata 0x8899AABB -> rdata_o 0x00008899.
REQ-036 BIG_ENDIAN=1, SH addr 0x3002, wdata 0x00001234 -> data_wstrb 0011, data_wdata 0x12341234, data_wr 1.
REQ-037 SW addr 0x4002 -> ades_o 1, badvaddr_o 0x4002, data_req never 1, stall_o 0.
REQ-038 LW accepted (addr_ok), flush_i in WAIT, data_ok 3 cycles later with 0xDEADBEEF -> stall_o held through DRAIN, no done_o, rdata_o unchanged.
REQ-039 rst asserted in WAIT, then data_ok the next cycle -> state IDLE, rdata_o 0, no done_o.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns an M-stage memory op into one SRAM-like
// request, waits for the response, and returns an extended load result.
// Misaligned accesses raise an address error instead of issuing a request.
module lsu_ctrl #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter bit ALIGN_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    // Opcode encodings shared with the decoder (MIPS primary opcodes).
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [5:0] op);
        logic [1:0] sz;
        sz = 2'd0;
        if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) sz = 2'd1;
        if ((op == OP_LW) || (op == OP_SW)) sz = 2'd2;
        return sz;
    endfunction

    logic [2:0]  state, state_nxt;
    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        in_load, in_store, in_misal, in_legal;
    logic [1:0]  in_size;
    logic [1:0]  q_size;
    logic [1:0]  q_off;
    logic [31:0] load_ext;

    // Classify the incoming op: memory type, size and alignment.
    always_comb begin
        in_load  = op_is_load(op_i);
        in_store = op_is_store(op_i);
        in_size  = op_size(op_i);
        in_misal = 1'b0;
        if (in_size == 2'd1) in_misal = addr_i[0];
        if (in_size == 2'd2) in_misal = |addr_i[1:0];
        in_legal = valid_i && (in_load || in_store) && !in_misal;
    end

    // Next-state logic; flush has priority over handshake progress.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_legal && !flush_i) state_nxt = S_REQ;
            S_REQ: begin
                if (flush_i)           state_nxt = S_IDLE;
                else if (data_addr_ok) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush_i)           state_nxt = data_data_ok ? S_IDLE : S_DRAIN;
                else if (data_data_ok) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_DRAIN: if (data_data_ok) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and the op/address/data captured at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && in_legal && !flush_i) begin
                op_q    <= op_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    // Pick the addressed lane from the response and extend it to 32 bits.
    always_comb begin
        logic [1:0]  lane;
        logic [31:0] shifted;
        logic        hi_half;
        logic [15:0] half;
        q_off    = addr_q[1:0];
        q_size   = op_size(op_q);
        lane     = BIG_ENDIAN ? (2'd3 - q_off) : q_off;
        shifted  = data_rdata >> {lane, 3'b000};
        hi_half  = BIG_ENDIAN ? !q_off[1] : q_off[1];
        half     = hi_half ? data_rdata[31:16] : data_rdata[15:0];
        load_ext = data_rdata;
        case (op_q)
            OP_LB:   load_ext = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_ext = {24'd0, shifted[7:0]};
            OP_LH:   load_ext = {{16{half[15]}}, half};
            OP_LHU:  load_ext = {16'd0, half};
            default: load_ext = data_rdata;
        endcase
    end

    // Load result register: only updated by a completing, unflushed load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o <= '0;
        end else if (state == S_WAIT && data_data_ok && !flush_i && op_is_load(op_q)) begin
            rdata_o <= load_ext;
        end
    end

    // Request channel driven from the latched op; withdrawn on flush.
    always_comb begin
        data_req   = (state == S_REQ) && !flush_i;
        data_wr    = op_is_store(op_q);
        data_size  = q_size;
        data_addr  = ALIGN_ADDR ? {addr_q[31:2], 2'b00} : addr_q;
        data_wdata = wdata_q;
        data_wstrb = 4'b0000;
        case (q_size)
            2'd0:    data_wdata = {4{wdata_q[7:0]}};
            2'd1:    data_wdata = {2{wdata_q[15:0]}};
            default: data_wdata = wdata_q;
        endcase
        if (op_is_store(op_q)) begin
            case (q_size)
                2'd0:    data_wstrb = 4'b0001 << (BIG_ENDIAN ? (2'd3 - q_off) : q_off);
                2'd1:    data_wstrb = (BIG_ENDIAN ? !q_off[1] : q_off[1]) ? 4'b1100 : 4'b0011;
                default: data_wstrb = 4'b1111;
            endcase
        end
    end

    // Pipeline handshake and address-error reporting.
    always_comb begin
        stall_o    = 1'b0;
        done_o     = 1'b0;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        badvaddr_o = addr_i;
        case (state)
            S_IDLE: begin
                stall_o = in_legal && !flush_i;
                adel_o  = valid_i && in_load && in_misal;
                ades_o  = valid_i && in_store && in_misal;
            end
            S_REQ, S_WAIT, S_DRAIN: stall_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one big-endian and one little-endian instance
// see the same stimulus; expected values are worked out by hand.
module tb_lsu_ctrl;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, flush_i;
    logic [5:0]  op_i;
    logic [31:0] addr_i, wdata_i;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    logic        be_stall, be_done, be_adel, be_ades, be_req, be_wr;
    logic [31:0] be_rdata, be_bad, be_addr, be_wdata;
    logic [1:0]  be_size;
    logic [3:0]  be_wstrb;

    logic        le_stall, le_done, le_adel, le_ades, le_req, le_wr;
    logic [31:0] le_rdata, le_bad, le_addr, le_wdata;
    logic [1:0]  le_size;
    logic [3:0]  le_wstrb;

    logic [31:0] cap_addr, cap_wdata;
    logic [1:0]  cap_size;
    logic [3:0]  cap_wstrb, cap_le_wstrb;
    logic        cap_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.BIG_ENDIAN(1'b1), .ALIGN_ADDR(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .flush_i(flush_i), .stall_o(be_stall), .done_o(be_done),
        .rdata_o(be_rdata), .adel_o(be_adel), .ades_o(be_ades), .badvaddr_o(be_bad),
        .data_req(be_req), .data_wr(be_wr), .data_size(be_size), .data_addr(be_addr),
        .data_wstrb(be_wstrb), .data_wdata(be_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    lsu_ctrl #(.BIG_ENDIAN(1'b0), .ALIGN_ADDR(1'b1)) dut_le (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .flush_i(flush_i), .stall_o(le_stall), .done_o(le_done),
        .rdata_o(le_rdata), .adel_o(le_adel), .ades_o(le_ades), .badvaddr_o(le_bad),
        .data_req(le_req), .data_wr(le_wr), .data_size(le_size), .data_addr(le_addr),
        .data_wstrb(le_wstrb), .data_wdata(le_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: addr_ok in the first REQ cycle, data_ok next cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd);
        valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
        #1;
        checkOutput("accept_stall", {31'd0, be_stall}, 32'd1);
        checkOutput("accept_noreq", {31'd0, be_req}, 32'd0);
        tick();
        valid_i = 1'b0; data_addr_ok = 1'b1;
        #1;
        checkOutput("req_valid", {31'd0, be_req}, 32'd1);
        cap_addr = be_addr; cap_wdata = be_wdata; cap_size = be_size;
        cap_wstrb = be_wstrb; cap_le_wstrb = le_wstrb; cap_wr = be_wr;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
        #1;
        checkOutput("wait_noreq", {31'd0, be_req}, 32'd0);
        checkOutput("wait_stall", {31'd0, be_stall}, 32'd1);
        tick();
        data_data_ok = 1'b0;
        checkOutput("done_latency", {31'd0, be_done}, 32'd1);
        checkOutput("done_nostall", {31'd0, be_stall}, 32'd0);
        tick();
        checkOutput("done_pulse", {31'd0, be_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = '0; addr_i = '0;
        wdata_i = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_stall", {31'd0, be_stall}, 32'd0);
        checkOutput("rst_done", {31'd0, be_done}, 32'd0);
        checkOutput("rst_rdata", be_rdata, 32'h0);
        checkOutput("rst_req", {31'd0, be_req}, 32'd0);
        tick();

        // LB big-endian: offset 1 -> bits [23:16] = 0x99, sign-extended
        applyStimulus(OP_LB, 32'h0000_1001, 32'h0, 32'h8899_AABB);
        checkOutput("lb_size", {30'd0, cap_size}, 32'd0);
        checkOutput("lb_addr", cap_addr, 32'h0000_1000);
        checkOutput("lb_wstrb", {28'd0, cap_wstrb}, 32'd0);
        checkOutput("lb_wr", {31'd0, cap_wr}, 32'd0);
        checkOutput("lb_rdata_be", be_rdata, 32'hFFFF_FF99);
        checkOutput("lb_rdata_le", le_rdata, 32'hFFFF_FFAA);

        // LHU offset 2: LE -> upper half, BE -> lower half
        applyStimulus(OP_LHU, 32'h0000_2002, 32'h0, 32'h8899_AABB);
        checkOutput("lhu_rdata_le", le_rdata, 32'h0000_8899);
        checkOutput("lhu_rdata_be", be_rdata, 32'h0000_AABB);
        checkOutput("lhu_size", {30'd0, cap_size}, 32'd1);

        // LBU offset 3: BE -> bits [7:0], LE -> bits [31:24]
        applyStimulus(OP_LBU, 32'h0000_0003, 32'h0, 32'h8899_AABB);
        checkOutput("lbu_rdata_be", be_rdata, 32'h0000_00BB);
        checkOutput("lbu_rdata_le", le_rdata, 32'h0000_0088);

        // LW passes the word through unchanged
        applyStimulus(OP_LW, 32'h0000_9004, 32'h0, 32'hCAFE_F00D);
        checkOutput("lw_rdata", be_rdata, 32'hCAFE_F00D);
        checkOutput("lw_size", {30'd0, cap_size}, 32'd2);

        // SH offset 2 big-endian: low lanes, replicated halfword
        applyStimulus(OP_SH, 32'h0000_3002, 32'h0000_1234, 32'h5555_5555);
        checkOutput("sh_wstrb_be", {28'd0, cap_wstrb}, 32'h3);
        checkOutput("sh_wstrb_le", {28'd0, cap_le_wstrb}, 32'hC);
        checkOutput("sh_wdata", cap_wdata, 32'h1234_1234);
        checkOutput("sh_wr", {31'd0, cap_wr}, 32'd1);
        checkOutput("sh_keep_rdata", be_rdata, 32'hCAFE_F00D);

        // Misaligned SW: address error, no request, no stall
        valid_i = 1'b1; op_i = OP_SW; addr_i = 32'h0000_4002;
        #1;
        checkOutput("sw_ades", {31'd0, be_ades}, 32'd1);
        checkOutput("sw_adel", {31'd0, be_adel}, 32'd0);
        checkOutput("sw_badv", be_bad, 32'h0000_4002);
        checkOutput("sw_stall", {31'd0, be_stall}, 32'd0);
        tick();
        checkOutput("sw_noreq", {31'd0, be_req}, 32'd0);
        op_i = OP_LH; addr_i = 32'h0000_5001;
        #1;
        checkOutput("lh_adel", {31'd0, be_adel}, 32'd1);
        checkOutput("lh_ades", {31'd0, be_ades}, 32'd0);
        tick();
        checkOutput("lh_noreq", {31'd0, be_req}, 32'd0);
        valid_i = 1'b0;
        tick();

        // Flush in WAIT: drain until data_ok, no done, rdata unchanged
        valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h0000_6000;
        tick();
        valid_i = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush_i = 1'b1;
        #1;
        checkOutput("fl_wait_stall", {31'd0, be_stall}, 32'd1);
        tick();
        flush_i = 1'b0;
        checkOutput("fl_drain_stall1", {31'd0, be_stall}, 32'd1);
        tick();
        checkOutput("fl_drain_stall2", {31'd0, be_stall}, 32'd1);
        checkOutput("fl_drain_nodone", {31'd0, be_done}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        tick();
        data_data_ok = 1'b0;
        checkOutput("fl_idle_stall", {31'd0, be_stall}, 32'd0);
        checkOutput("fl_nodone", {31'd0, be_done}, 32'd0);
        checkOutput("fl_rdata", be_rdata, 32'hCAFE_F00D);
        tick();
        checkOutput("fl_nodone2", {31'd0, be_done}, 32'd0);

        // Flush in REQ withdraws the request
        valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h0000_7000;
        tick();
        valid_i = 1'b0; flush_i = 1'b1;
        #1;
        checkOutput("flreq_withdrawn", {31'd0, be_req}, 32'd0);
        tick();
        flush_i = 1'b0;
        checkOutput("flreq_idle_stall", {31'd0, be_stall}, 32'd0);
        checkOutput("flreq_idle_req", {31'd0, be_req}, 32'd0);

        // Reset mid-WAIT, stale data_ok afterwards is ignored
        valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h0000_8000;
        tick();
        valid_i = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1122_3344;
        #1;
        checkOutput("rstw_rdata", be_rdata, 32'h0);
        checkOutput("rstw_stall", {31'd0, be_stall}, 32'd0);
        tick();
        data_data_ok = 1'b0;
        checkOutput("rstw_nodone", {31'd0, be_done}, 32'd0);
        checkOutput("rstw_rdata2", be_rdata, 32'h0);
        checkOutput("rstw_noreq", {31'd0, be_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
